// File: rtl/mb_downconverter_n_if.sv
// Bundles the upstream fetch port and the narrow downstream bus of
// mb_downconverter_n into a single interface.
//   slave  : view taken by the downconverter
//   master : view taken by whatever drives it (fetch unit and memory side)
// Signals:
//   u_req_addr/u_req_active         upstream word request
//   u_req_data/u_req_data_valid     assembled word and its one-cycle strobe
//   d_req_addr/d_req_active         downstream beat request
//   d_req_data/d_req_data_valid     downstream beat return
//   d_req_next                      burst-continuation pulse
//   busy                            downconverter not idle
interface mb_downconverter_n_if #(
    parameter int DW    = 16,
    parameter int RATIO = 2,
    parameter int AW    = 16
);
    localparam int UW = DW * RATIO;

    logic [AW-1:0] u_req_addr;
    logic          u_req_active;
    logic [UW-1:0] u_req_data;
    logic          u_req_data_valid;
    logic [AW-1:0] d_req_addr;
    logic          d_req_active;
    logic [DW-1:0] d_req_data;
    logic          d_req_data_valid;
    logic          d_req_next;
    logic          busy;

    modport slave (
        input  u_req_addr, u_req_active, d_req_data, d_req_data_valid,
        output u_req_data, u_req_data_valid, d_req_addr, d_req_active,
               d_req_next, busy
    );

    modport master (
        output u_req_addr, u_req_active, d_req_data, d_req_data_valid,
        input  u_req_data, u_req_data_valid, d_req_addr, d_req_active,
               d_req_next, busy
    );
endinterface

// File: rtl/mb_downconverter_n.sv
// Fetch-path width downconverter: one upstream request for a RATIO*DW word
// is served as RATIO sequential DW-bit downstream beats, then returned as a
// single assembled word with a one-cycle valid strobe.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      mb_downconverter_n_if.slave (upstream + downstream signals)
//
// state | meaning
// IDLE  | no request; latch address when u_req_active rises
// FETCH | beat outstanding at {a_q, beat_q}
// DONE  | word assembled; raise u_req_data_valid for one cycle
// HOLD  | word delivered; wait for withdrawal or new address
// DRAIN | request withdrawn mid-word; wait out the outstanding beat
module mb_downconverter_n #(
    parameter int DW    = 16,
    parameter int RATIO = 2,
    parameter int AW    = 16
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    mb_downconverter_n_if.slave bus
);
    localparam int UW = DW * RATIO;
    localparam int LR = $clog2(RATIO);
    localparam logic [LR-1:0] LAST_BEAT = LR'(RATIO - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DONE, S_HOLD, S_DRAIN} state_t;

    state_t           state_q;
    logic [AW-LR-1:0] a_q;
    logic [LR-1:0]    beat_q;
    logic [UW-1:0]    buf_q;
    logic [UW-1:0]    word_d;
    logic [UW-1:0]    data_q;
    logic             valid_q;
    logic [AW-1:0]    d_addr_q;
    logic             d_act_q;
    logic             d_next_q;
    logic             busy_q;

    logic [AW-LR-1:0] addr_lo;
    logic             abort;
    logic             unused_addr_hi;

    // Address bits above the word index cannot be represented in the beat
    // address, so they are dropped and play no part in address compares.
    assign addr_lo        = bus.u_req_addr[AW-LR-1:0];
    assign unused_addr_hi = ^bus.u_req_addr[AW-1:AW-LR];
    assign abort          = !bus.u_req_active || (addr_lo != a_q);

    always_comb begin
        word_d = buf_q;
        word_d[int'(beat_q)*DW +: DW] = bus.d_req_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            beat_q   <= '0;
            buf_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            d_addr_q <= '0;
            d_act_q  <= 1'b0;
            d_next_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            d_next_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.u_req_active) begin
                        a_q      <= addr_lo;
                        beat_q   <= '0;
                        d_addr_q <= {addr_lo, {LR{1'b0}}};
                        d_act_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.d_req_data_valid) begin
                        buf_q <= word_d;
                        // Final beat completes even if the request was
                        // withdrawn in the same cycle.
                        if (beat_q == LAST_BEAT) begin
                            data_q  <= word_d;
                            d_act_q <= 1'b0;
                            state_q <= S_DONE;
                        end else if (abort) begin
                            // Beat just completed, nothing left outstanding.
                            d_act_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            beat_q   <= beat_q + 1'b1;
                            d_addr_q <= {a_q, beat_q + 1'b1};
                            d_next_q <= 1'b1;
                        end
                    end else if (abort) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.u_req_active) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (addr_lo != a_q) begin
                        a_q      <= addr_lo;
                        beat_q   <= '0;
                        d_addr_q <= {addr_lo, {LR{1'b0}}};
                        d_act_q  <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.d_req_data_valid) begin
                        d_act_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.u_req_data       = data_q;
    assign bus.u_req_data_valid = valid_q;
    assign bus.d_req_addr       = d_addr_q;
    assign bus.d_req_active     = d_act_q;
    assign bus.d_req_next       = d_next_q;
    assign bus.busy             = busy_q;
endmodule

// File: doc/mb_downconverter_n.md
Name: mb_downconverter_n

Overview:
- Parametrised fetch-path width downconverter: one upstream request of RATIO*DW bits becomes RATIO sequential downstream beats of DW bits; results are assembled into one upstream word.
- Sits between the instruction-fetch unit and the narrow memory bus arbiter.
- Adds over the 2:1 version: any power-of-two ratio, registered output data, explicit abort/drain on upstream withdrawal or address change, and no refetch of a completed request.

Parameters:
- DW, 16: downstream data width.
- RATIO, 2: beats per upstream word; power of two, 2..8.
- AW, 16: address width, both sides.
- UW, DW*RATIO: upstream data width; derived, not overridable.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- u_req_addr  in  AW  upstream word address, UW-sized units
- u_req_active  in  1  upstream request; held with stable address until valid
- u_req_data  out  UW  assembled word; beat k occupies bits [k*DW +: DW]
- u_req_data_valid  out  1  one-cycle pulse; u_req_data valid
- d_req_addr  out  AW  downstream address, {u_req_addr[AW-1-log2(RATIO):0], beat}
- d_req_active  out  1  downstream request; high while a beat is outstanding
- d_req_data  in  DW  downstream read data
- d_req_data_valid  in  1  one-cycle pulse completing the outstanding beat
- d_req_next  out  1  one-cycle pulse when d_req_addr advances to beat>0 (burst continuation)
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, beat=0, u_req_data=0, u_req_data_valid=0, d_req_active=0, d_req_next=0, d_req_addr=0, busy=0.
- All outputs are registered. Upstream address bits above AW-log2(RATIO) are dropped; the top bits of d_req_addr wrap.
- FSM states:
  - IDLE: if u_req_active, latch addr to a_q, beat=0, go to FETCH; d_req_active rises next cycle.
  - FETCH: d_req_active=1 and d_req_addr={a_q,beat}. On d_req_data_valid, store d_req_data in slot beat.
    - If beat<RATIO-1: beat+1; d_req_next pulses in the same cycle the new address appears.
    - If beat==RATIO-1: drive u_req_data, go to DONE.
  - DONE: u_req_data_valid=1 for exactly one cycle, d_req_active=0, then go to HOLD.
  - HOLD: no downstream activity. Exit to IDLE when u_req_active=0; exit to FETCH with a new latch when u_req_addr!=a_q and u_req_active=1. Same address held produces no refetch and no second pulse.
  - DRAIN: entered from FETCH when u_req_active falls or u_req_addr!=a_q before the final beat completes.
    - Keep d_req_active and d_req_addr unchanged until d_req_data_valid, and discard that data. No u_req_data_valid.
    - Then go to IDLE; the new request is taken from IDLE one cycle later.
- Abort coinciding with the final beat's d_req_data_valid: the completion wins, i.e. go to DONE and pulse valid with the latched-address data.
- d_req_data_valid outside FETCH or DRAIN: ignored.
- Minimum latency: request seen in IDLE at cycle 0 → d_req_active at cycle 1 → with zero-wait memory, valid pulse at cycle RATIO+2.
- u_req_data holds its last value between pulses.
- Reset asserted mid-operation: immediate return to reset values; the partial word is lost.

Test Plan:
- RATIO=2, DW=16: addr 0x0012, zero-wait memory returning 0xBEEF then 0x1234 → d_req_addr 0x0024, 0x0025; d_req_next one pulse; one valid pulse with u_req_data=0x1234BEEF at cycle 4.
- RATIO=4, DW=8: addr 0x0003, 2-cycle wait per beat returning 0x11,0x22,0x33,0x44 → addrs 0x000C..0x000F; 3 d_req_next pulses; u_req_data=0x44332211; one valid pulse.
- Hold u_req_active high with the same address for 10 cycles after valid → no further d_req_active and no second valid pulse; then change addr to 0x0013 → new fetch of 0x0026/0x0027.
- Drop u_req_active during beat 0 with a 3-cycle memory wait → d_req_active held until that beat's data valid, data discarded, no upstream valid, busy falls.
- Change addr 0x0012→0x0040 on the same cycle as the final-beat data valid → valid pulse with the 0x0012 data, HOLD, then fetch of 0x0080/0x0081.
- Assert i_rst_n=0 mid-beat asynchronously → all outputs 0 before the next clock edge; clean fetch after release.
